// File: rtl/ir_scan_pkg.sv
// Shared types and constants for the IR line-sensor scan sequencer.
// Optional build macro IR_SCAN_SAT_EN selects saturation of the published
// error; the saturation limits live here.
package ir_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CNV_R,
    WAIT_R,
    CNV_L,
    WAIT_L,
    ACCUM,
    DONE
  } state_t;

  localparam int NUM_PAIRS = 3;

  // Pair index, visited in this order
  localparam logic [1:0] PAIR_IN  = 2'd0;
  localparam logic [1:0] PAIR_MID = 2'd1;
  localparam logic [1:0] PAIR_OUT = 2'd2;

  // A2D channel for the right and left sensor of each pair
  localparam logic [2:0] CH_R_IN  = 3'd1;
  localparam logic [2:0] CH_L_IN  = 3'd0;
  localparam logic [2:0] CH_R_MID = 3'd4;
  localparam logic [2:0] CH_L_MID = 3'd2;
  localparam logic [2:0] CH_R_OUT = 3'd3;
  localparam logic [2:0] CH_L_OUT = 3'd7;

  // Outer pairs see the line later, so they are weighted more heavily
  localparam logic signed [15:0] W_IN  = 16'sd1;
  localparam logic signed [15:0] W_MID = 16'sd2;
  localparam logic signed [15:0] W_OUT = 16'sd4;

  // Signed 12-bit range used when saturation is built in
  localparam logic signed [15:0] SAT_MAX = 16'sd2047;
  localparam logic signed [15:0] SAT_MIN = -16'sd2048;

  function automatic logic [2:0] chan_r(input logic [1:0] pair);
    case (pair)
      PAIR_IN:  chan_r = CH_R_IN;
      PAIR_MID: chan_r = CH_R_MID;
      default:  chan_r = CH_R_OUT;
    endcase
  endfunction

  function automatic logic [2:0] chan_l(input logic [1:0] pair);
    case (pair)
      PAIR_IN:  chan_l = CH_L_IN;
      PAIR_MID: chan_l = CH_L_MID;
      default:  chan_l = CH_L_OUT;
    endcase
  endfunction

  function automatic logic signed [15:0] pair_weight(input logic [1:0] pair);
    case (pair)
      PAIR_IN:  pair_weight = W_IN;
      PAIR_MID: pair_weight = W_MID;
      default:  pair_weight = W_OUT;
    endcase
  endfunction

endpackage

// File: rtl/ir_settle_tmr.sv
// Emitter settle timer: loadable down-counter. A load pulse arms it so that
// expire is high on the SETTLE_CYCLES-th cycle after the load edge.
module ir_settle_tmr #(
  parameter int unsigned SETTLE_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam logic [15:0] LOAD_VAL = 16'(SETTLE_CYCLES - 1);

  logic [15:0] cnt_reg;

  // Count down to zero after a load and park there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= LOAD_VAL;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 16'd1;
    end
  end

  assign expire = (cnt_reg == '0);

endmodule

// File: rtl/ir_scan_seq.sv
// IR line-sensor scan sequencer: for each of three emitter pairs, settle the
// emitter, convert right then left sensor, and accumulate the weighted
// difference into a signed line error. Build with IR_SCAN_SAT_EN defined to
// clamp the published error to the signed 12-bit range.
module ir_scan_seq
  import ir_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  output logic        IR_in_en,
  output logic        IR_mid_en,
  output logic        IR_out_en,
  output logic [2:0]  chnnl,
  output logic        strt_cnv,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        busy,
  output logic [15:0] error,
  output logic        done
);

  state_t             state_reg, state_next;
  logic [1:0]         pair_reg, pair_next;
  logic [11:0]        r_reg, l_reg;
  logic signed [15:0] acc_reg;
  logic signed [15:0] error_reg;
  logic               done_reg;
  logic               settle_load;
  logic               settle_expire;
  logic               emit_on;
  logic [NUM_PAIRS-1:0] ir_en;

  logic signed [12:0] diff;
  logic signed [15:0] diff_ext;
  logic signed [15:0] weighted;
  logic signed [15:0] err_pub;

  ir_settle_tmr #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_tmr (
    .clk   (clk),
    .rst   (rst),
    .load  (settle_load),
    .expire(settle_expire)
  );

  // Both readings are unsigned, so zero-extend before subtracting
  assign diff     = $signed({1'b0, l_reg}) - $signed({1'b0, r_reg});
  assign diff_ext = {{3{diff[12]}}, diff};
  assign weighted = diff_ext * pair_weight(pair_reg);

`ifdef IR_SCAN_SAT_EN
  assign err_pub = (acc_reg > SAT_MAX) ? SAT_MAX :
                   (acc_reg < SAT_MIN) ? SAT_MIN : acc_reg;
`else
  assign err_pub = acc_reg;
`endif

  // State and pair-index register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pair_reg  <= PAIR_IN;
    end else begin
      state_reg <= state_next;
      pair_reg  <= pair_next;
    end
  end

  // Next-state decode plus Moore outputs for emitter, channel and start
  always_comb begin
    state_next  = state_reg;
    pair_next   = pair_reg;
    settle_load = 1'b0;
    emit_on     = 1'b0;
    strt_cnv    = 1'b0;
    chnnl       = 3'd0;
    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next  = SETTLE;
          pair_next   = PAIR_IN;
          settle_load = 1'b1;
        end
      end
      SETTLE: begin
        emit_on = 1'b1;
        if (settle_expire) state_next = CNV_R;
      end
      CNV_R: begin
        emit_on    = 1'b1;
        strt_cnv   = 1'b1;
        chnnl      = chan_r(pair_reg);
        state_next = WAIT_R;
      end
      WAIT_R: begin
        emit_on = 1'b1;
        chnnl   = chan_r(pair_reg);
        if (cnv_cmplt) state_next = CNV_L;
      end
      CNV_L: begin
        emit_on    = 1'b1;
        strt_cnv   = 1'b1;
        chnnl      = chan_l(pair_reg);
        state_next = WAIT_L;
      end
      WAIT_L: begin
        emit_on = 1'b1;
        chnnl   = chan_l(pair_reg);
        if (cnv_cmplt) state_next = ACCUM;
      end
      ACCUM: begin
        if (pair_reg == PAIR_OUT) begin
          state_next = DONE;
        end else begin
          state_next  = SETTLE;
          pair_next   = pair_reg + 2'd1;
          settle_load = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture A2D results and run the weighted accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg   <= '0;
      l_reg   <= '0;
      acc_reg <= '0;
    end else begin
      if (state_reg == IDLE && go)            acc_reg <= '0;
      if (state_reg == WAIT_R && cnv_cmplt)   r_reg   <= res;
      if (state_reg == WAIT_L && cnv_cmplt)   l_reg   <= res;
      if (state_reg == ACCUM)                 acc_reg <= acc_reg + weighted;
    end
  end

  // Publish the finished error together with a one-cycle done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= (state_reg == DONE);
      if (state_reg == DONE) error_reg <= err_pub;
    end
  end

  // Only the pair currently being scanned gets its emitter
  for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_emit
    assign ir_en[gi] = emit_on && (pair_reg == 2'(gi));
  end

  assign IR_in_en  = ir_en[0];
  assign IR_mid_en = ir_en[1];
  assign IR_out_en = ir_en[2];
  assign busy      = (state_reg != IDLE);
  assign error     = error_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_ir_scan_seq.sv
// Directed testbench for ir_scan_seq with a fixed-latency A2D model.
module tb_ir_scan_seq;

  localparam int S_CYC   = 4;
  localparam int A2D_LAT = 8;
  // go-sampling edge to done edge: 3*(S+5) + 1 + six waits of (LAT-1)
  localparam int EXP_LAT = 3 * (S_CYC + 5) + 1 + 6 * (A2D_LAT - 1);

`ifdef IR_SCAN_SAT_EN
  localparam logic [15:0] EXP_SAT = 16'h07FF;
  localparam logic [15:0] EXP_NEG = 16'hF800;
`else
  localparam logic [15:0] EXP_SAT = 16'h1000;
  localparam logic [15:0] EXP_NEG = 16'h9007;
`endif

  logic        clk;
  logic        rst;
  logic        go;
  logic        IR_in_en, IR_mid_en, IR_out_en;
  logic [2:0]  chnnl;
  logic        strt_cnv;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        busy;
  logic [15:0] error;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int idle_entries = 0;
  logic prev_busy = 1'b0;

  logic [11:0] res_tab [8];
  logic        spur_req = 1'b0;
  logic [2:0]  chan_log [$];
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [11:0] pend_val = '0;

  ir_scan_seq #(.SETTLE_CYCLES(S_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .IR_in_en (IR_in_en),
    .IR_mid_en(IR_mid_en),
    .IR_out_en(IR_out_en),
    .chnnl    (chnnl),
    .strt_cnv (strt_cnv),
    .cnv_cmplt(cnv_cmplt),
    .res      (res),
    .busy     (busy),
    .error    (error),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A2D model: answers A2D_LAT cycles after strt_cnv; can inject a spurious pulse
  initial begin
    cnv_cmplt = 1'b0;
    res = '0;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      res = '0;
      if (spur_req) begin
        cnv_cmplt = 1'b1;
        res = 12'hABC;
      end
      if (pend) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          cnv_cmplt = 1'b1;
          res = pend_val;
          pend = 1'b0;
        end
      end
      if (strt_cnv && !rst) begin
        chan_log.push_back(chnnl);
        pend = 1'b1;
        pend_cnt = A2D_LAT;
        pend_val = res_tab[chnnl];
      end
    end
  end

  // One cycle: advance to the falling edge and run the per-cycle checks
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      checks++;
      if ($countones({IR_in_en, IR_mid_en, IR_out_en}) > 1) begin
        errors++;
        $display("FAIL emit_onehot: got %b required at most one set", {IR_in_en, IR_mid_en, IR_out_en});
      end
      checks++;
      if (strt_cnv && !(IR_in_en || IR_mid_en || IR_out_en)) begin
        errors++;
        $display("FAIL strt_no_emit: got strt_cnv=1 emitters=000 required an emitter on");
      end
    end
    if (done) done_cnt++;
    if (prev_busy && !busy) idle_entries++;
    prev_busy = busy;
  endtask

  task automatic set_tab(input logic [11:0] r_in, input logic [11:0] l_in,
                         input logic [11:0] r_mid, input logic [11:0] l_mid,
                         input logic [11:0] r_out, input logic [11:0] l_out);
    res_tab[1] = r_in;  res_tab[0] = l_in;
    res_tab[4] = r_mid; res_tab[2] = l_mid;
    res_tab[3] = r_out; res_tab[7] = l_out;
    res_tab[5] = 12'h000; res_tab[6] = 12'h000;
  endtask

  // One full scan from IDLE; optionally inject a cnv_cmplt during SETTLE
  task automatic run_scan(input logic [15:0] exp_err, input bit spur, input string tag);
    int  go_cyc;
    int  d0;
    int  base;
    bit  seen;
    logic [2:0] exp_ch [6];
    exp_ch = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    tick();
    base = chan_log.size();
    d0 = done_cnt;
    go = 1'b1;
    go_cyc = cyc + 1;
    if (spur) begin
      @(posedge clk); #1;
      go = 1'b0;
      spur_req = 1'b1;
      @(posedge clk); #1;
      spur_req = 1'b0;
      checks++;
      if (busy !== 1'b1 || strt_cnv !== 1'b0 || chnnl !== 3'd0) begin
        errors++;
        $display("FAIL %s_spur_state: got busy=%b strt=%b ch=%0d required 1 0 0", tag, busy, strt_cnv, chnnl);
      end
    end else begin
      tick();
      go = 1'b0;
    end
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      tick();
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no done required done within 400 cycles", tag);
    end else begin
      checks++;
      if ((cyc - go_cyc) != EXP_LAT) begin
        errors++;
        $display("FAIL %s_latency: got %0d required %0d", tag, cyc - go_cyc, EXP_LAT);
      end
      checks++;
      if (error !== exp_err) begin
        errors++;
        $display("FAIL %s_error: got %h required %h", tag, error, exp_err);
      end
    end
    repeat (4) tick();
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d required 1", tag, done_cnt - d0);
    end
    checks++;
    if (error !== exp_err) begin
      errors++;
      $display("FAIL %s_error_held: got %h required %h", tag, error, exp_err);
    end
    checks++;
    if (chan_log.size() != base + 6) begin
      errors++;
      $display("FAIL %s_conv_count: got %0d required 6", tag, chan_log.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (chan_log[base + i] !== exp_ch[i]) begin
          errors++;
          $display("FAIL %s_chan%0d: got %0d required %0d", tag, i, chan_log[base + i], exp_ch[i]);
        end
      end
    end
    $display("scan %s: error=%h", tag, error);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    go = 1'b0;
    repeat (3) tick();
    checks++;
    if ({IR_in_en, IR_mid_en, IR_out_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_emit: got %b required 000", {IR_in_en, IR_mid_en, IR_out_en});
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || strt_cnv !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b done=%b strt=%b required 0 0 0", busy, done, strt_cnv);
    end
    checks++;
    if (chnnl !== 3'd0) begin
      errors++;
      $display("FAIL reset_chnnl: got %0d required 0", chnnl);
    end
    checks++;
    if (error !== 16'h0000) begin
      errors++;
      $display("FAIL reset_error: got %h required 0000", error);
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b required 0 without go", busy);
    end
    $display("reset: busy=%b error=%h", busy, error);
  endtask

  task automatic test_basic();
    set_tab(12'h800, 12'h900, 12'h555, 12'h555, 12'h123, 12'h123);
    run_scan(16'h0100, 1'b0, "basic");
  endtask

  task automatic test_saturation();
    set_tab(12'h400, 12'h400, 12'h000, 12'h000, 12'h200, 12'h600);
    run_scan(EXP_SAT, 1'b0, "sat");
  endtask

  task automatic test_negative();
    set_tab(12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000);
    run_scan(EXP_NEG, 1'b0, "neg");
  endtask

  task automatic test_spurious();
    set_tab(12'h800, 12'h900, 12'h555, 12'h555, 12'h123, 12'h123);
    run_scan(16'h0100, 1'b1, "spur");
  endtask

  task automatic test_go_held();
    int d0;
    int i0;
    bit idle;
    tick();
    d0 = done_cnt;
    i0 = idle_entries;
    go = 1'b1;
    repeat (150) tick();
    go = 1'b0;
    idle = 1'b0;
    for (int n = 0; n < 200 && !idle; n++) begin
      tick();
      if (!busy) idle = 1'b1;
    end
    repeat (2) tick();
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL held_timeout: got busy=1 required idle within 200 cycles");
    end
    checks++;
    if (done_cnt - d0 != 3) begin
      errors++;
      $display("FAIL held_done_count: got %0d required 3", done_cnt - d0);
    end
    checks++;
    if (idle_entries - i0 != done_cnt - d0) begin
      errors++;
      $display("FAIL held_done_per_idle: got idle=%0d done=%0d required equal", idle_entries - i0, done_cnt - d0);
    end
    checks++;
    if (error !== 16'h0100) begin
      errors++;
      $display("FAIL held_error: got %h required 0100", error);
    end
    $display("go_held: dones=%0d error=%h", done_cnt - d0, error);
  endtask

  task automatic test_reset_mid();
    int  d0;
    bit  found;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      tick();
      if (IR_mid_en && chnnl == 3'd2 && !strt_cnv) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rmid_find: got no mid WAIT_L required one within 300 cycles");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({IR_in_en, IR_mid_en, IR_out_en} !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: got emit=%b busy=%b required 000 0", {IR_in_en, IR_mid_en, IR_out_en}, busy);
    end
    checks++;
    if (error !== 16'h0000 || chnnl !== 3'd0) begin
      errors++;
      $display("FAIL rmid_clear: got error=%h ch=%0d required 0000 0", error, chnnl);
    end
    repeat (2) tick();
    rst = 1'b0;
    d0 = done_cnt;
    repeat (120) tick();
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL rmid_no_done: got %0d done pulses required 0", done_cnt - d0);
    end
    checks++;
    if (busy !== 1'b0 || error !== 16'h0000) begin
      errors++;
      $display("FAIL rmid_abort: got busy=%b error=%h required 0 0000", busy, error);
    end
    $display("reset_mid: busy=%b error=%h", busy, error);
  endtask

  initial begin
    rst = 1'b1;
    go = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_negative();
    test_spurious();
    test_go_held();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ir_scan_seq.md
IR_SCAN_SEQ -- requirements
Module: ir_scan_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4096, emitter-on cycles before the first conversion of each pair (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have port go, input, 1, request a full three-pair scan.
REQ-005 SHALL have ports IR_in_en / IR_mid_en / IR_out_en, output, 1 each, emitter enables for the inner, middle and outer pairs.
REQ-006 SHALL have port chnnl, output, 3, A2D channel select for the current conversion.
REQ-007 SHALL have port strt_cnv, output, 1, one-cycle conversion request to the A2D interface.
REQ-008 SHALL have port cnv_cmplt, input, 1, A2D conversion-complete pulse.
REQ-009 SHALL have port res, input, 12, unsigned A2D result, valid while cnv_cmplt=1.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port error, output, 16, signed weighted line error, held between scans.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when error updates.

Function
REQ-013 SHALL use the states IDLE, SETTLE, CNV_R, WAIT_R, CNV_L, WAIT_L, ACCUM, DONE.
REQ-014 SHALL visit pairs in the order inner, mid, outer, with channels (R,L) = (1,0), (4,2), (3,7).
REQ-015 SHALL sample go only in IDLE; go=1 there moves to SETTLE for the inner pair and clears the accumulator.
REQ-016 SHALL ignore go in every other state, including DONE.
REQ-017 SHALL assert only the current pair's emitter, and only in SETTLE, CNV_R, WAIT_R, CNV_L and WAIT_L; at most one emitter is high in any cycle.
REQ-018 SHALL stay in SETTLE exactly SETTLE_CYCLES cycles, then go to CNV_R.
REQ-019 SHALL pulse strt_cnv for exactly one cycle in CNV_R and in CNV_L, with chnnl valid in that cycle; chnnl holds until the matching cnv_cmplt.
REQ-020 SHALL stay in WAIT_R or WAIT_L until cnv_cmplt=1, capturing res in that cycle; there is no timeout.
REQ-021 SHALL ignore cnv_cmplt in every state other than WAIT_R and WAIT_L.
REQ-022 SHALL compute, in ACCUM, diff = L - R as 13-bit signed and add diff*W to a 16-bit signed accumulator, with W = 1, 2, 4 for inner, mid, outer.
REQ-023 SHALL, after ACCUM, go to SETTLE for the next pair, or to DONE after the outer pair.
REQ-024 SHALL, in DONE, load error from the accumulator, pulse done for one cycle, then return to IDLE.
REQ-025 SHALL give a go-to-done latency of 3*(SETTLE_CYCLES + 5) + 1 + total A2D wait cycles, where a WAIT state exited on its first cycle counts 0.

Reset
REQ-026 SHALL, while rst=1, force the state to IDLE, all emitters to 0, strt_cnv=0, done=0, busy=0, chnnl=0, error=0 and the accumulator to 0, asynchronously.
REQ-027 SHALL treat reset mid-scan as an abort: no partial error is published, and the next scan needs a new go.

Configuration
REQ-028 SHALL, with IR_SCAN_SAT_EN defined, saturate error in DONE to the signed 12-bit range [-2048, +2047], sign-extended to 16 bits.
REQ-029 SHALL, without IR_SCAN_SAT_EN, publish the full 16-bit accumulator, which cannot overflow (|error| <= 28665).

Structure
REQ-030 SHALL take the following from package ir_scan_pkg: the state enum typedef, the per-pair channel constants, the pair weights and the saturation limits.
REQ-031 SHALL implement the settle delay in sub-module ir_settle_tmr, a loadable down-counter with load input and expire output.

Verification
REQ-032 SHALL cover the basic scan: SETTLE_CYCLES=4, A2D model answers 8 cycles after strt_cnv, inner R=0x800 L=0x900, mid and outer equal -> error=0x0100 and done pulses once.
REQ-033 SHALL cover saturation: outer L-R=+0x400, others 0 -> error=0x1000 without IR_SCAN_SAT_EN, 0x07FF with it.
REQ-034 SHALL cover the negative extreme: all pairs R=0xFFF L=0x000 -> error=-28665 (0x9007) without the macro, -2048 (0xF800) with it.
REQ-035 SHALL cover protocol checks: go held high through a whole scan -> exactly one done per IDLE entry; a spurious cnv_cmplt in SETTLE -> no state change, channel order 1,0,4,2,3,7 on strt_cnv cycles.
REQ-036 SHALL cover reset mid-scan: rst asserted in WAIT_L of the mid pair -> emitters and busy drop in the same cycle, error=0, no done pulse.
REQ-037 SHALL check on every cycle that at most one emitter is high, and that strt_cnv never fires with all emitters low.
